wishbone_ram_arbiter: RTL and testbench

//  Two-master Wishbone classic arbiter in front of the SRAM/ROM address-decode mux upstream port.

---
 rtl/wishbone_ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wishbone_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_ram_arbiter.sv
// Round-robin two-master Wishbone classic arbiter for the SRAM/ROM mux port.
// Define ARB_TIMEOUT_EN to add the watchdog that completes unacked transfers.
module wishbone_ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_m0_cyc_i,
  input  logic        wbs_m0_stb_i,
  input  logic        wbs_m0_we_i,
  input  logic [3:0]  wbs_m0_sel_i,
  input  logic [31:0] wbs_m0_adr_i,
  input  logic [31:0] wbs_m0_dat_i,
  output logic        wbs_m0_ack_o,
  output logic [31:0] wbs_m0_dat_o,
  input  logic        wbs_m1_cyc_i,
  input  logic        wbs_m1_stb_i,
  input  logic        wbs_m1_we_i,
  input  logic [3:0]  wbs_m1_sel_i,
  input  logic [31:0] wbs_m1_adr_i,
  input  logic [31:0] wbs_m1_dat_i,
  output logic        wbs_m1_ack_o,
  output logic [31:0] wbs_m1_dat_o,
  output logic        wbs_dfp_cyc_o,
  output logic        wbs_dfp_stb_o,
  output logic        wbs_dfp_we_o,
  output logic [3:0]  wbs_dfp_sel_o,
  output logic [31:0] wbs_dfp_adr_o,
  output logic [31:0] wbs_dfp_dat_o,
  input  logic        wbs_dfp_ack_i,
  input  logic [31:0] wbs_dfp_dat_i,
  output logic [1:0]  arb_grant_o,
  output logic        arb_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
`ifdef ARB_TIMEOUT_EN
    , S_TOUT = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_set_last;
  logic   w_last_val;
  logic   w_req0;
  logic   w_req1;

  assign w_req0 = wbs_m0_cyc_i & wbs_m0_stb_i;
  assign w_req1 = wbs_m1_cyc_i & wbs_m1_stb_i;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic          w_expire;

  assign w_expire = (r_cnt == LIM) & ~wbs_dfp_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt   <= '0;
      r_owner <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt   <= '0;
        r_owner <= (w_next == S_GNT1);
      end else if (r_state != S_TOUT && !wbs_dfp_ack_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^TIMEOUT_DATA ^ (TIMEOUT_CYCLES < 2);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_set_last) r_last <= w_last_val;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_last    = 1'b0;
    w_last_val    = r_last;
    wbs_dfp_cyc_o = 1'b0;
    wbs_dfp_stb_o = 1'b0;
    wbs_dfp_we_o  = 1'b0;
    wbs_dfp_sel_o = '0;
    wbs_dfp_adr_o = '0;
    wbs_dfp_dat_o = '0;
    wbs_m0_ack_o  = 1'b0;
    wbs_m0_dat_o  = '0;
    wbs_m1_ack_o  = 1'b0;
    wbs_m1_dat_o  = '0;
    arb_grant_o   = 2'b00;
    arb_timeout_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // On a tie, the master that did not go last wins
        if (w_req0 && w_req1) w_next = r_last ? S_GNT0 : S_GNT1;
        else if (w_req0)      w_next = S_GNT0;
        else if (w_req1)      w_next = S_GNT1;
      end
      S_GNT0: begin
        arb_grant_o   = 2'b01;
        wbs_dfp_cyc_o = wbs_m0_cyc_i;
        wbs_dfp_stb_o = wbs_m0_stb_i;
        wbs_dfp_we_o  = wbs_m0_we_i;
        wbs_dfp_sel_o = wbs_m0_sel_i;
        wbs_dfp_adr_o = wbs_m0_adr_i;
        wbs_dfp_dat_o = wbs_m0_dat_i;
        wbs_m0_ack_o  = wbs_dfp_ack_i;
        wbs_m0_dat_o  = wbs_dfp_dat_i;
        if (!wbs_m0_cyc_i) begin
          w_next = S_IDLE;
        end else if (wbs_dfp_ack_i && wbs_m0_stb_i) begin
          w_next     = S_IDLE;
          w_set_last = 1'b1;
          w_last_val = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_expire) w_next = S_TOUT;
`endif
      end
      S_GNT1: begin
        arb_grant_o   = 2'b10;
        wbs_dfp_cyc_o = wbs_m1_cyc_i;
        wbs_dfp_stb_o = wbs_m1_stb_i;
        wbs_dfp_we_o  = wbs_m1_we_i;
        wbs_dfp_sel_o = wbs_m1_sel_i;
        wbs_dfp_adr_o = wbs_m1_adr_i;
        wbs_dfp_dat_o = wbs_m1_dat_i;
        wbs_m1_ack_o  = wbs_dfp_ack_i;
        wbs_m1_dat_o  = wbs_dfp_dat_i;
        if (!wbs_m1_cyc_i) begin
          w_next = S_IDLE;
        end else if (wbs_dfp_ack_i && wbs_m1_stb_i) begin
          w_next     = S_IDLE;
          w_set_last = 1'b1;
          w_last_val = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_expire) w_next = S_TOUT;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      S_TOUT: begin
        arb_grant_o   = r_owner ? 2'b10 : 2'b01;
        arb_timeout_o = 1'b1;
        wbs_m0_ack_o  = ~r_owner;
        wbs_m1_ack_o  = r_owner;
        wbs_m0_dat_o  = r_owner ? 32'h0 : TIMEOUT_DATA;
        wbs_m1_dat_o  = r_owner ? TIMEOUT_DATA : 32'h0;
        w_next        = S_IDLE;
        w_set_last    = 1'b1;
        w_last_val    = r_owner;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_ram_arbiter.sv
// Directed and randomized checks of wishbone_ram_arbiter against a transfer-level model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_wishbone_ram_arbiter;
  localparam int unsigned T = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic        clk = 0;
  logic        rst = 0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_adr, d_wdat;
  logic        d_ack = 0;
  logic [31:0] d_rdat = 0;
  logic [1:0]  grant;
  logic        tout;

  int total = 0;
  int bad = 0;

  wishbone_ram_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDATA)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_m0_cyc_i(m0_cyc), .wbs_m0_stb_i(m0_stb), .wbs_m0_we_i(m0_we),
    .wbs_m0_sel_i(m0_sel), .wbs_m0_adr_i(m0_adr), .wbs_m0_dat_i(m0_dat),
    .wbs_m0_ack_o(m0_ack), .wbs_m0_dat_o(m0_rd),
    .wbs_m1_cyc_i(m1_cyc), .wbs_m1_stb_i(m1_stb), .wbs_m1_we_i(m1_we),
    .wbs_m1_sel_i(m1_sel), .wbs_m1_adr_i(m1_adr), .wbs_m1_dat_i(m1_dat),
    .wbs_m1_ack_o(m1_ack), .wbs_m1_dat_o(m1_rd),
    .wbs_dfp_cyc_o(d_cyc), .wbs_dfp_stb_o(d_stb), .wbs_dfp_we_o(d_we),
    .wbs_dfp_sel_o(d_sel), .wbs_dfp_adr_o(d_adr), .wbs_dfp_dat_o(d_wdat),
    .wbs_dfp_ack_i(d_ack), .wbs_dfp_dat_i(d_rdat),
    .arb_grant_o(grant), .arb_timeout_o(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    d_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    quiet();
    step();
    step();
    rst = 0;
  endtask

  task automatic req0(input logic [31:0] a, input logic we,
                      input logic [31:0] d, input logic [3:0] s);
    m0_cyc = 1; m0_stb = 1; m0_we = we;
    m0_adr = a; m0_dat = d; m0_sel = s;
  endtask

  task automatic req1(input logic [31:0] a, input logic we,
                      input logic [31:0] d, input logic [3:0] s);
    m1_cyc = 1; m1_stb = 1; m1_we = we;
    m1_adr = a; m1_dat = d; m1_sel = s;
  endtask

  // transfer-level reference model
  int          own;
  bit          mt;
  bit          last;
  int          busy;
  bit          act[2];
  bit          gack[2];
  logic [31:0] ra[2], rd[2];
  logic [3:0]  rs[2];
  logic        rw[2];

  initial begin
    logic [1:0]  eg;
    logic        ecyc, eto;
    logic [31:0] eadr;
    logic        ea[2];
    logic [31:0] ed[2];

    do_reset();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_dcyc", d_cyc, 0);
    chk("rst_m0ack", m0_ack, 0);
    chk("rst_m1ack", m1_ack, 0);
    chk("rst_tout", tout, 0);

    req0(32'h3000_0004, 0, 32'h0, 4'hF);
    #1 chk("lat_grant", grant, 2'b00);
    step(); #1;
    chk("rd_grant", grant, 2'b01);
    chk("rd_dstb", d_stb, 1);
    chk("rd_dadr", d_adr, 32'h3000_0004);
    chk("rd_dwe", d_we, 0);
    chk("rd_noack", m0_ack, 0);
    step();
    d_ack = 1; d_rdat = 32'h1234_5678;
    #1;
    chk("rd_ack", m0_ack, 1);
    chk("rd_dat", m0_rd, 32'h1234_5678);
    chk("rd_m1ack", m1_ack, 0);
    step();
    quiet();
    #1;
    chk("rd_rel", grant, 2'b00);
    chk("rd_ackoff", m0_ack, 0);

    do_reset();
    req0(32'h3000_0100, 0, 0, 4'hF);
    req1(32'h3000_0200, 0, 0, 4'hF);
    step(); #1;
    chk("tie0_grant", grant, 2'b01);
    d_ack = 1;
    step();
    m0_cyc = 0; m0_stb = 0; d_ack = 0;
    #1 chk("tie0_rel", grant, 2'b00);
    step(); #1;
    chk("tie0_m1", grant, 2'b10);
    d_ack = 1;
    step();
    quiet();
    for (int k = 0; k < 3; k++) begin
      req0(32'h3000_0300, 0, 0, 4'hF);
      req1(32'h3000_0400, 0, 0, 4'hF);
      step(); #1;
      chk("tie_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      d_ack = 1;
      #1;
      chk("tie_ack0", m0_ack, (k % 2 == 0));
      chk("tie_ack1", m1_ack, (k % 2 == 1));
      step();
      quiet();
      #1 chk("tie_idle", grant, 2'b00);
    end

    req1(32'h3004_0010, 1, 32'hA5A5_A5A5, 4'b0011);
    step(); #1;
    chk("wr_grant", grant, 2'b10);
    chk("wr_we", d_we, 1);
    chk("wr_adr", d_adr, 32'h3004_0010);
    chk("wr_dat", d_wdat, 32'hA5A5_A5A5);
    chk("wr_sel", d_sel, 4'b0011);
    chk("wr_m0ack", m0_ack, 0);
    d_ack = 1;
    #1;
    chk("wr_m1ack", m1_ack, 1);
    chk("wr_m0ack2", m0_ack, 0);
    step();
    quiet();
    #1 chk("wr_m0ack3", m0_ack, 0);

    req1(32'h3000_0008, 0, 0, 4'hF);
    step(); #1;
    chk("rg_grant", grant, 2'b10);
    rst = 1;
    step();
    rst = 0;
    d_ack = 1;
    #1;
    chk("rg_grant0", grant, 2'b00);
    chk("rg_dcyc", d_cyc, 0);
    chk("rg_m1ack", m1_ack, 0);
    quiet();
    step();
    req0(32'h3000_0010, 0, 0, 4'hF);
    req1(32'h3000_0014, 0, 0, 4'hF);
    step(); #1;
    chk("rg_tie", grant, 2'b01);
    d_ack = 1;
    step();
    quiet();

    req0(32'h300F_0000, 0, 0, 4'hF);
    step();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < int'(T); k++) begin
      #1;
      chk("wd_busy", m0_ack, 0);
      chk("wd_nopulse", tout, 0);
      step();
    end
    #1;
    chk("wd_ack", m0_ack, 1);
    chk("wd_dat", m0_rd, TDATA);
    chk("wd_pulse", tout, 1);
    chk("wd_dcyc", d_cyc, 0);
    quiet();
    step(); #1;
    chk("wd_idle", grant, 2'b00);
    chk("wd_pulse_end", tout, 0);
    req0(32'h300F_0004, 0, 0, 4'hF);
    step();
    for (int k = 0; k < int'(T) - 1; k++) step();
    d_ack = 1; d_rdat = 32'h0000_0055;
    #1;
    chk("wd_race_ack", m0_ack, 1);
    chk("wd_race_dat", m0_rd, 32'h0000_0055);
    chk("wd_race_tout", tout, 0);
    step();
    quiet();
    #1;
    chk("wd_race_idle", grant, 2'b00);
    chk("wd_race_tout2", tout, 0);
`else
    for (int k = 0; k < 100; k++) begin
      #1;
      chk("hold_grant", grant, 2'b01);
      chk("hold_tout", tout, 0);
      step();
    end
    quiet();
    step(); #1;
    chk("hold_abort", grant, 2'b00);
`endif

    req0(32'h3000_0020, 0, 0, 4'hF);
    step(); #1;
    chk("ab_grant", grant, 2'b01);
    req1(32'h3000_0024, 0, 0, 4'hF);
    step();
    m0_cyc = 0; m0_stb = 0;
    #1 chk("ab_m0ack", m0_ack, 0);
    step(); #1;
    chk("ab_idle", grant, 2'b00);
    chk("ab_m1ack", m1_ack, 0);
    step(); #1;
    chk("ab_m1", grant, 2'b10);
    d_ack = 1;
    step();
    quiet();

    do_reset();
    own = -1; mt = 0; last = 1; busy = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; gack[i] = 0;
      ra[i] = 0; rd[i] = 0; rs[i] = 0; rw[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && (gack[i] || $urandom_range(0, 24) == 0)) begin
          act[i] = 0;
        end else if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1;
          ra[i] = $urandom; rd[i] = $urandom;
          rs[i] = 4'($urandom); rw[i] = 1'($urandom);
        end
      end
      m0_cyc = act[0]; m0_stb = act[0]; m0_we = rw[0];
      m0_adr = ra[0]; m0_dat = rd[0]; m0_sel = rs[0];
      m1_cyc = act[1]; m1_stb = act[1]; m1_we = rw[1];
      m1_adr = ra[1]; m1_dat = rd[1]; m1_sel = rs[1];
      d_ack = ($urandom_range(0, 2) == 0);
      d_rdat = $urandom;
      #1;
      eg = 0; ecyc = 0; eadr = 0; eto = 0;
      ea[0] = 0; ea[1] = 0; ed[0] = 0; ed[1] = 0;
      if (mt) begin
        eg = (own == 0) ? 2'b01 : 2'b10;
        ea[own] = 1; ed[own] = TDATA; eto = 1;
      end else if (own >= 0) begin
        eg = (own == 0) ? 2'b01 : 2'b10;
        ecyc = act[own]; eadr = ra[own];
        ea[own] = d_ack; ed[own] = d_rdat;
      end
      chk("rnd_grant", grant, eg);
      chk("rnd_dcyc", d_cyc, ecyc);
      chk("rnd_dadr", d_adr, eadr);
      chk("rnd_m0ack", m0_ack, ea[0]);
      chk("rnd_m1ack", m1_ack, ea[1]);
      chk("rnd_m0dat", m0_rd, ed[0]);
      chk("rnd_m1dat", m1_rd, ed[1]);
      chk("rnd_tout", tout, eto);
      gack[0] = ea[0]; gack[1] = ea[1];
      if (mt) begin
        mt = 0; last = (own == 1); own = -1;
      end else if (own >= 0) begin
        if (!act[own]) begin
          own = -1;
        end else if (d_ack) begin
          last = (own == 1); own = -1;
        end else begin
          busy++;
`ifdef ARB_TIMEOUT_EN
          if (busy == int'(T)) mt = 1;
`endif
        end
      end else begin
        busy = 0;
        if (act[0] && act[1]) own = last ? 0 : 1;
        else if (act[0]) own = 0;
        else if (act[1]) own = 1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
